// File: rtl/simple_cnt_core.sv
// Up-counter with programmable wrap threshold, terminal-count pulse and a
// zero-wait-state valid/ready register file (CTRL, STATUS, THR).
module simple_cnt_core #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         reg_valid_i,
    input  logic         reg_write_i,
    input  logic [3:0]   reg_wstrb_i,
    input  logic [31:0]  reg_addr_i,
    input  logic [31:0]  reg_wdata_i,
    output logic         reg_error_o,
    output logic         reg_ready_o,
    output logic [31:0]  reg_rdata_o,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    output logic [W-1:0] cnt_o,
    output logic         clr_o,
    output logic         tc_o
);

    generate
        if (W < 1 || W > 32) begin : g_bad_w
            $error("simple_cnt_core: W must be in 1..32");
        end
    endgenerate

    logic         en;
    logic         clr;
    logic         tc_sticky;
    logic [31:0]  thr;
    logic [W-1:0] cnt;

    logic [3:0] off;
    logic       hit_ctrl, hit_status, hit_thr, mapped;
    logic       wr_ctrl, wr_status, wr_thr;
    logic       at_thr;

    assign off        = reg_addr_i[3:0];
    assign hit_ctrl   = (off == 4'h0);
    assign hit_status = (off == 4'h4);
    assign hit_thr    = (off == 4'h8);
    assign mapped     = hit_ctrl | hit_status | hit_thr;

    assign wr_ctrl    = reg_valid_i & reg_write_i & hit_ctrl;
    assign wr_status  = reg_valid_i & reg_write_i & hit_status;
    assign wr_thr     = reg_valid_i & reg_write_i & hit_thr;

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i & ~mapped;

    always_comb begin
        reg_rdata_o = 32'h0;
        if (reg_valid_i) begin
            if (hit_ctrl)   reg_rdata_o = {31'h0, en};
            if (hit_status) reg_rdata_o = {31'h0, tc_sticky};
            if (hit_thr)    reg_rdata_o = thr;
        end
    end

    assign at_thr = (cnt == thr[W-1:0]);
    assign tc_o   = en & ~clr & ~ld_i & at_thr;
    assign cnt_o  = cnt;
    assign clr_o  = clr;

    // CLR is a one-shot: it only lives for the cycle after the CTRL write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en  <= 1'b0;
            clr <= 1'b0;
        end else begin
            clr <= wr_ctrl & reg_wstrb_i[0] & reg_wdata_i[1];
            if (wr_ctrl && reg_wstrb_i[0]) en <= reg_wdata_i[0];
        end
    end

    // A new terminal count beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tc_sticky <= 1'b0;
        end else if (tc_o) begin
            tc_sticky <= 1'b1;
        end else if (wr_status && reg_wstrb_i[0] && reg_wdata_i[0]) begin
            tc_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thr <= 32'hFFFF_FFFF;
        end else if (wr_thr) begin
            for (int b = 0; b < 4; b++)
                if (reg_wstrb_i[b]) thr[8*b +: 8] <= reg_wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          cnt <= '0;
        else if (clr)         cnt <= '0;
        else if (ld_i)        cnt <= ld_val_i;
        else if (en && at_thr) cnt <= '0;
        else if (en)          cnt <= cnt + W'(1);
    end

    logic unused_addr;
    assign unused_addr = ^reg_addr_i[31:4];

endmodule

// File: tb/tb_simple_cnt_core.sv
// Randomized + directed bench for simple_cnt_core, checked every cycle
// against a cycle-level behavioural model of the register map and counter.
module tb_simple_cnt_core;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid, write;
    logic [3:0]   wstrb;
    logic [31:0]  addr, wdata;
    logic         err, ready;
    logic [31:0]  rdata;
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] cnt;
    logic         clr, tc;

    always #5 clk = ~clk;

    simple_cnt_core #(.W(W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .reg_valid_i(valid), .reg_write_i(write), .reg_wstrb_i(wstrb),
        .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_error_o(err), .reg_ready_o(ready), .reg_rdata_o(rdata),
        .ld_i(ld), .ld_val_i(ld_val),
        .cnt_o(cnt), .clr_o(clr), .tc_o(tc)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference state
    logic [W-1:0] m_cnt;
    logic         m_en, m_clr, m_sticky;
    logic [31:0]  m_thr;
    logic         e_tc;

    function automatic logic [31:0] m_reg(input logic [3:0] o);
        case (o)
            4'h0:    return {31'h0, m_en};
            4'h4:    return {31'h0, m_sticky};
            4'h8:    return m_thr;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_mapped(input logic [3:0] o);
        return (o == 4'h0) || (o == 4'h4) || (o == 4'h8);
    endfunction

    task automatic m_reset();
        m_cnt = '0; m_en = 0; m_clr = 0; m_sticky = 0; m_thr = 32'hFFFF_FFFF;
    endtask

    task automatic check_now();
        logic [3:0] o;
        @(negedge clk);
        o = addr[3:0];
        e_tc = m_en && !m_clr && !ld && (m_cnt == m_thr[W-1:0]);
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("tc", 32'(tc), 32'(e_tc));
        chk("clr", 32'(clr), 32'(m_clr));
        chk("ready", 32'(ready), 32'(valid));
        chk("error", 32'(err), 32'(valid && !is_mapped(o)));
        if (!(valid && write))
            chk("rdata", rdata, valid ? m_reg(o) : 32'h0);
    endtask

    task automatic advance();
        logic [3:0]   o;
        bit           wr;
        logic [W-1:0] n_cnt;
        o  = addr[3:0];
        wr = valid && write && is_mapped(o);
        if (m_clr)                                    n_cnt = '0;
        else if (ld)                                  n_cnt = ld_val;
        else if (m_en && m_cnt == m_thr[W-1:0])       n_cnt = '0;
        else if (m_en)                                n_cnt = m_cnt + 1'b1;
        else                                          n_cnt = m_cnt;
        @(posedge clk);
        m_cnt = n_cnt;
        if (e_tc) m_sticky = 1;
        else if (wr && o == 4'h4 && wstrb[0] && wdata[0]) m_sticky = 0;
        m_clr = wr && o == 4'h0 && wstrb[0] && wdata[1];
        if (wr && o == 4'h0 && wstrb[0]) m_en = wdata[0];
        if (wr && o == 4'h8)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) m_thr[8*b +: 8] = wdata[8*b +: 8];
        #1;
    endtask

    task automatic step();
        check_now();
        advance();
    endtask

    task automatic bus_idle();
        valid = 0; write = 0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        valid = 1; write = 1; addr = a; wstrb = s; wdata = d;
        step();
        bus_idle();
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        valid = 1; write = 0; addr = a; wstrb = 4'h0; wdata = 32'h0;
        check_now();
        chk(tag, rdata, exp);
        advance();
        bus_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int tc_seen;
        bus_idle();
        ld = 0; ld_val = '0;
        rst_n = 0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk("rst_tc", 32'(tc), 32'h0);
        chk("rst_clr", 32'(clr), 32'h0);
        @(posedge clk); #1;
        rst_n = 1;

        // Reset register values
        rd("rst_ctrl", 32'h0, 32'h0);
        rd("rst_status", 32'h4, 32'h0);
        rd("rst_thr", 32'h8, 32'hFFFF_FFFF);

        // Basic counting with THR=3
        wr(32'h8, 4'hF, 32'd3);
        wr(32'h0, 4'hF, 32'd1);
        tc_seen = 0;
        for (int i = 0; i < 12; i++) begin
            check_now();
            if (tc) begin
                tc_seen++;
                chk("tc_at_thr", 32'(cnt), 32'd3);
            end
            advance();
        end
        chk("tc_pulses", tc_seen, 3);
        rd("status_set", 32'h4, 32'h1);
        wr(32'h0, 4'hF, 32'd0);
        wr(32'h4, 4'hF, 32'd1);
        rd("status_w1c", 32'h4, 32'h0);

        // Clear while counting at 2
        wr(32'h0, 4'hF, 32'd1);
        for (int i = 0; i < 8 && cnt != 2; i++) step();
        chk("at_two", 32'(cnt), 32'd2);
        wr(32'h0, 4'hF, 32'd3);
        check_now();
        chk("clr_pulse", 32'(clr), 32'd1);
        advance();
        check_now();
        chk("clr_zero", 32'(cnt), 32'd0);
        chk("clr_drop", 32'(clr), 32'd0);
        advance();
        rd("ctrl_clr_reads0", 32'h0, 32'h1);

        // Load above threshold: runs up through 2^W wrap without TC
        ld = 1; ld_val = W'(10);
        step();
        ld = 0;
        chk("ld_val", 32'(cnt), 32'd10);
        tc_seen = 0;
        for (int i = 0; i < (1 << W) - 10; i++) begin
            check_now();
            if (tc) tc_seen++;
            advance();
        end
        chk("no_tc_above", tc_seen, 0);
        chk("wrap_zero", 32'(cnt), 32'd0);
        idle(3);
        check_now();
        chk("tc_after_wrap", 32'(tc), 32'd1);
        advance();

        // Same-cycle clear and load: clear wins
        wr(32'h0, 4'hF, 32'd3);
        ld = 1; ld_val = W'(77);
        step();
        ld = 0;
        chk("clr_over_ld", 32'(cnt), 32'd0);

        // Byte strobes and unmapped offsets
        wr(32'h8, 4'hF, 32'hFFFF_FFFF);
        wr(32'h8, 4'h1, 32'h1234_5678);
        rd("thr_strb", 32'h8, 32'hFFFF_FF78);
        wr(32'hC, 4'hF, 32'h0);
        rd("err_c", 32'hC, 32'h0);
        rd("err_2", 32'h2, 32'h0);
        rd("thr_intact", 32'h8, 32'hFFFF_FF78);

        // EN=0 holds, no TC even at threshold
        wr(32'h0, 4'hF, 32'd0);
        wr(32'h8, 4'hF, 32'(cnt));
        idle(5);
        chk("hold_tc", 32'(tc), 32'd0);

        // THR=0: tc every cycle
        wr(32'h8, 4'hF, 32'd0);
        wr(32'h0, 4'hF, 32'd3);
        idle(4);
        chk("thr0_tc", 32'(tc), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            valid = ($urandom_range(0, 99) < 35);
            write = $urandom_range(0, 1);
            sel   = $urandom_range(0, 5);
            case (sel)
                0: addr = 32'h0;
                1: addr = 32'h4;
                2: addr = 32'h8;
                3: addr = 32'hC;
                4: addr = 32'h2;
                default: addr = $urandom;
            endcase
            wstrb = 4'($urandom);
            wdata = (sel == 2 && $urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 15)) : $urandom;
            if (sel == 0 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
            ld     = ($urandom_range(0, 99) < 4);
            ld_val = W'($urandom);
            step();
        end
        bus_idle();
        ld = 0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_cnt_core.md
Name: simple_cnt_core

Overview:
- Up-counter with a memory-mapped control/status register file.
- Counts while enabled and wraps to 0 at a programmable threshold, raising a one-cycle terminal-count (TC) pulse.
- Register port: simple valid/ready register bus. Direct load port lets an external bus bridge preload the count.
- Sits under the bus wrapper that drives the load port and exports tc_o as an interrupt.

Parameters:
- W, 32, counter bitwidth; legal range 1..32; elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- reg_valid_i  in  1  register access request
- reg_write_i  in  1  1 = write, 0 = read
- reg_wstrb_i  in  4  write byte strobes
- reg_addr_i  in  32  byte address; only addr[3:0] decoded
- reg_wdata_i  in  32  write data
- reg_error_o  out  1  access to unmapped offset
- reg_ready_o  out  1  access complete
- reg_rdata_o  out  32  read data
- ld_i  in  1  load counter with ld_val_i
- ld_val_i  in  W  load value
- cnt_o  out  W  current count
- clr_o  out  1  clear pulse currently applied to the counter
- tc_o  out  1  terminal-count pulse

Behaviour:
- Register map (offset = addr[3:0]):
  - 0x0 CTRL: bit0 EN (rw, reset 0); bit1 CLR (write-1 self-clearing, reads 0).
  - 0x4 STATUS: bit0 TC (sticky; write-1-to-clear; reset 0).
  - 0x8 THR: 32-bit threshold (rw, reset 0xFFFF_FFFF); counter compares against THR[W-1:0].
  - Unused bits read 0.
- Bus handshake: single-cycle, zero wait states. reg_ready_o = reg_valid_i combinationally; reg_rdata_o is combinational from the current register state.
  - Writes take effect at the clock edge where valid & write.
  - Only bytes with wstrb set are updated; the W1C and CLR bits act only if their byte strobe is set.
- Unmapped offset (anything other than 0x0/0x4/0x8, including misaligned): reg_error_o = valid, rdata = 0, write ignored. Otherwise reg_error_o = 0.
- Reset: all registers to reset values; cnt_o = 0, clr_o = 0, tc_o = 0, reg_* outputs follow their combinational rules (0 with valid low).
- Clear: writing CTRL with bit1 = 1 sets the internal clear flag for exactly the next cycle (clr_o = 1 that cycle), then it auto-drops. The EN bit written in the same access takes effect normally.
- Counter next-state priority per edge:
  1. clr_o → 0
  2. else ld_i → ld_val_i
  3. else EN and cnt == thr → 0
  4. else EN → cnt + 1 (mod 2^W)
  5. else hold
- tc_o = EN & ~clr_o & ~ld_i & (cnt_o == THR[W-1:0]); combinational. It is high for the one cycle preceding the wrap to 0.
- Count above threshold (e.g. after a load): keeps incrementing, wraps at 2^W-1 → 0 with no TC, then reaches thr normally.
- STATUS.TC is set on the edge where tc_o = 1. Set wins over a simultaneous W1C.
- THR = 0 with EN: count stays at 0, tc_o high every cycle.
- Changing THR while counting takes effect immediately for the comparison.

Test Plan:
- Reset → read CTRL = 0, STATUS = 0, THR = 0xFFFFFFFF; cnt_o = 0; tc_o = 0; ready follows valid; error = 0.
- Write THR = 3, CTRL = 1 → cnt_o sequence 0,1,2,3,0,1…; tc_o high only while cnt_o = 3; STATUS reads 1; writing STATUS = 1 clears it to 0.
- While counting at 2, write CTRL = 0x3 → clr_o high one cycle, cnt_o = 0 next cycle, then resumes counting; CTRL reads 0x1.
- ld_i = 1, ld_val_i = 10 with THR = 3, EN = 1 → cnt_o = 10, increments without tc_o until wrap to 0 at 2^W, then tc_o at 3. Same-cycle clr and ld → cnt_o = 0.
- Write THR with wstrb = 0b0001, data 0x12345678 → THR reads 0xFFFFFF78. Access offset 0xC or 0x2 → error = 1, rdata = 0, no state change.
- EN = 0 → cnt_o holds value and tc_o = 0 even when cnt_o equals thr.
